// File: rtl/grey_seq_ctrl_if.sv
// rtl/grey_seq_ctrl_if.sv - control, stream and status signals of grey_seq_ctrl
interface grey_seq_ctrl_if;
  logic       start;
  logic       abort;
  logic       dir;
  logic [3:0] ld_idx;
  logic [4:0] len;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] code;
  logic [3:0] idx;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       err;

  modport slave (
    input  start, abort, dir, ld_idx, len, out_ready,
    output out_valid, code, idx, busy, done, wrap, err
  );

  modport master (
    output start, abort, dir, ld_idx, len, out_ready,
    input  out_valid, code, idx, busy, done, wrap, err
  );
endinterface

// File: rtl/grey_seq_ctrl.sv
// rtl/grey_seq_ctrl.sv - Gray-code table sequencer with ready/valid output
// Optional adjacency checker enabled by defining GREY_SEQ_CHECK_EN.
module grey_seq_ctrl (
  input logic            clk,
  input logic            rst,
  grey_seq_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [4:0] rem_q, rem_d;
  logic       dir_q, dir_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;

  logic       xfer;
  logic       start_acc;
  logic [3:0] idx_step;
  logic       step_wraps;

  function automatic logic [3:0] gray_lut(input logic [3:0] i);
    case (i)
      4'd0:  gray_lut = 4'h5;
      4'd1:  gray_lut = 4'h4;
      4'd2:  gray_lut = 4'hC;
      4'd3:  gray_lut = 4'hD;
      4'd4:  gray_lut = 4'hF;
      4'd5:  gray_lut = 4'hE;
      4'd6:  gray_lut = 4'hA;
      4'd7:  gray_lut = 4'hB;
      4'd8:  gray_lut = 4'h9;
      4'd9:  gray_lut = 4'h8;
      4'd10: gray_lut = 4'h0;
      4'd11: gray_lut = 4'h1;
      4'd12: gray_lut = 4'h3;
      4'd13: gray_lut = 4'h2;
      4'd14: gray_lut = 4'h6;
      default: gray_lut = 4'h7;
    endcase
  endfunction

  assign xfer       = (state_q == RUN) && bus.out_ready;
  assign start_acc  = (state_q == IDLE) && bus.start && !bus.abort;
  assign idx_step   = dir_q ? idx_q + 4'd1 : idx_q - 4'd1;
  assign step_wraps = dir_q ? (idx_q == 4'hF) : (idx_q == 4'h0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          idx_d   = bus.ld_idx;
          dir_d   = bus.dir;
          rem_d   = (bus.len == 5'd0 || bus.len > 5'd16) ? 5'd16 : bus.len;
          state_d = RUN;
        end
      end
      default: begin
        if (xfer) begin
          if (rem_q > 5'd1) begin
            idx_d  = idx_step;
            rem_d  = rem_q - 5'd1;
            wrap_d = step_wraps;
          end else begin
            state_d = IDLE;
            rem_d   = 5'd0;
            done_d  = !bus.abort;
          end
        end
        // A transfer coinciding with abort still counts, but the run ends here.
        if (bus.abort) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      rem_q   <= 5'd0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out_valid = (state_q == RUN);
  assign bus.busy      = (state_q == RUN);
  assign bus.code      = gray_lut(idx_q);
  assign bus.idx       = idx_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

`ifdef GREY_SEQ_CHECK_EN
  logic [3:0] last_q, last_d;
  logic       have_q, have_d;
  logic       err_q, err_d;
  logic [3:0] diff;

  always_comb begin
    last_d = last_q;
    have_d = have_q;
    err_d  = err_q;
    diff   = last_q ^ bus.code;
    if (start_acc) begin
      err_d  = 1'b0;
      have_d = 1'b0;
    end else if (xfer) begin
      if (have_q && !$onehot(diff)) err_d = 1'b1;
      last_d = bus.code;
      have_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 4'd0;
      have_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      have_q <= have_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
